// File: rtl/pmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : pmem_loader
// Brief    : Byte-stream program-memory loader. Frames a 16-bit word count
//            followed by little-endian data words, holding the core in reset
//            until the image is written. Optional trailing XOR checksum is
//            enabled by defining PMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module pmem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_reset,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    FLUSH  = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
`ifdef PMEM_LOADER_CHECKSUM_EN
    , CHECK = 3'd7
`endif
  } state_t;

  localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word_lo;
  logic        w_rx_state;
  logic        w_accept;
  logic [15:0] w_len_full;
  logic        w_len_bad;
  logic        w_last_word;
`ifdef PMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  always_comb begin
    w_rx_state = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
`ifdef PMEM_LOADER_CHECKSUM_EN
    w_rx_state = w_rx_state || (r_state == CHECK);
`endif
  end

  assign byte_ready  = w_rx_state && !start;
  assign w_accept    = byte_valid && byte_ready;
  assign w_len_full  = {byte_data, r_len[7:0]};
  assign w_len_bad   = (w_len_full == 16'd0) || ({16'd0, w_len_full} > c_depth);
  assign w_last_word = (r_word_idx == (r_len - 16'd1));

  assign busy       = w_rx_state || (r_state == FLUSH);
  assign core_reset = (r_state == RUN);
  assign error      = (r_state == ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = LEN_LO;
    end else begin
      case (r_state)
        LEN_LO: if (w_accept) w_state_nxt = LEN_HI;
        LEN_HI: if (w_accept) w_state_nxt = w_len_bad ? ERR : DATA;
        DATA:   if (w_accept && (r_byte_cnt == 2'd3) && w_last_word) w_state_nxt = FLUSH;
`ifdef PMEM_LOADER_CHECKSUM_EN
        FLUSH:  w_state_nxt = CHECK;
        CHECK:  if (w_accept) w_state_nxt = (byte_data == r_xor) ? RUN : ERR;
`else
        FLUSH:  w_state_nxt = RUN;
`endif
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Bytes 0..2 of a word collect in r_word_lo; the write fires on byte 3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len      <= 16'd0;
      r_word_idx <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_word_lo  <= 24'd0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 32'd0;
`ifdef PMEM_LOADER_CHECKSUM_EN
      r_xor      <= 8'd0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        r_len      <= 16'd0;
        r_word_idx <= 16'd0;
        r_byte_cnt <= 2'd0;
`ifdef PMEM_LOADER_CHECKSUM_EN
        r_xor      <= 8'd0;
`endif
      end else if (w_accept) begin
        case (r_state)
          LEN_LO: r_len[7:0]  <= byte_data;
          LEN_HI: r_len[15:8] <= byte_data;
          DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PMEM_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ byte_data;
`endif
            if (r_byte_cnt == 2'd3) begin
              wr_en      <= 1'b1;
              wr_addr    <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
              wr_data    <= {byte_data, r_word_lo};
              r_word_idx <= r_word_idx + 16'd1;
            end else begin
              r_word_lo  <= {byte_data, r_word_lo[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_loader
// Brief    : Self-checking bench for pmem_loader (table vectors, directed
//            corner cases, randomized loads against a stream-level model).
// Revision : 1.0
// ============================================================================
module tb_pmem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_reset;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  pmem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .busy       (busy),
    .error      (error)
  );

  typedef struct packed {
    int          nb;
    logic [95:0] seq;   // first byte in the most significant occupied position
    logic        gap;
    int          nw;
    logic [63:0] w0;    // {addr, data}
    logic [63:0] w1;
    logic        err;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         overlap = 0;
  logic [63:0] got[$];
  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];

  always @(negedge clk) begin
    if (wr_en) got.push_back({wr_addr, wr_data});
    if (wr_en && core_reset) overlap++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    #1 check("ready_in_start_cycle", 64'(byte_ready), 64'd0);
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    bit acc;
    t = 0;
    acc = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!acc && t < 20) begin
      #1 acc = byte_ready;
      @(negedge clk);
      t++;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: ready never seen for byte %h", b);
    end
  endtask

  // Stream-level reference: word i of the image lands at BASE + 4*i.
  task automatic model(output bit e_err);
    int n;
    exp_q.delete();
    n = {16'd0, stim[1], stim[0]};
    e_err = (n == 0) || (n > DEPTH);
    if (!e_err)
      for (int i = 0; i < n; i++)
        exp_q.push_back({BASE + 32'(4 * i), stim[2+4*i+3], stim[2+4*i+2],
                         stim[2+4*i+1], stim[2+4*i]});
  endtask

  task automatic run_load(input bit gap, input string tag);
    bit e_err;
    model(e_err);
`ifdef PMEM_LOADER_CHECKSUM_EN
    if (!e_err) begin
      logic [7:0] x;
      x = 8'd0;
      for (int i = 2; i < stim.size(); i++) x ^= stim[i];
      stim.push_back(x);
    end
`endif
    got.delete();
    pulse_start();
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i]);
      if (gap && i != stim.size() - 1) @(negedge clk);
    end
    if (!e_err) begin
`ifdef PMEM_LOADER_CHECKSUM_EN
      check({tag, "_run_after_check"}, 64'(core_reset), 64'd1);
`else
      check({tag, "_last_write_timing"}, 64'({wr_en, core_reset}), 64'b10);
      @(negedge clk);
      check({tag, "_core_reset_rise"}, 64'({wr_en, core_reset}), 64'b01);
`endif
    end
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), (i < got.size()) ? got[i] : '1, exp_q[i]);
    check({tag, "_final_flags"}, 64'({error, core_reset, busy}), 64'({e_err, !e_err, 1'b0}));
    if (!e_err)
      check({tag, "_hold"}, {wr_addr, wr_data}, exp_q[exp_q.size()-1]);
  endtask

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10, 96'h0200_1305_1000_9305_2000, 1'b0, 2,
                64'h0000_0000_0010_0513, 64'h0000_0004_0020_0593, 1'b0};
    vecs[1] = '{10, 96'h0200_1305_1000_9305_2000, 1'b1, 2,
                64'h0000_0000_0010_0513, 64'h0000_0004_0020_0593, 1'b0};
    vecs[2] = '{2, 96'h0000, 1'b0, 0, 64'd0, 64'd0, 1'b1};
    vecs[3] = '{2, 96'h0101, 1'b0, 0, 64'd0, 64'd0, 1'b1};
    vecs[4] = '{6, 96'h0100_EFBE_ADDE, 1'b1, 1,
                64'h0000_0000_DEAD_BEEF, 64'd0, 1'b0};

    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #1;
    check("reset_flags", 64'({byte_ready, wr_en, busy, error, core_reset}), 64'd0);
    check("reset_bus", {wr_addr, wr_data}, {BASE, 32'd0});
    repeat (3) @(negedge clk);
    reset = 1'b1;

    begin
      int bad;
      bad = 0;
      repeat (100) begin
        @(negedge clk);
        if (core_reset || busy || wr_en) bad++;
      end
      check("idle_100_cycles", 64'(bad), 64'd0);
      check("idle_no_writes", 64'(got.size()), 64'd0);
    end

    for (int v = 0; v < 5; v++) begin
      stim.delete();
      for (int i = 0; i < vecs[v].nb; i++)
        stim.push_back(vecs[v].seq[8*(vecs[v].nb-1-i) +: 8]);
      run_load(vecs[v].gap, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_nw", v), 64'(got.size()), 64'(vecs[v].nw));
      if (vecs[v].nw > 0) check($sformatf("vec%0d_tbl_w0", v), got[0], vecs[v].w0);
      if (vecs[v].nw > 1) check($sformatf("vec%0d_tbl_w1", v), got[1], vecs[v].w1);
      check($sformatf("vec%0d_tbl_err", v), 64'(error), 64'(vecs[v].err));
    end

    // Abort after 6 data bytes, then a fresh one-word load.
    pulse_start();
    begin
      logic [7:0] ab[8];
      ab = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
      for (int i = 0; i < 8; i++) send_byte(ab[i]);
    end
    check("abort_busy_midload", 64'({busy, core_reset}), 64'b10);
    stim.delete();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(1'b0, "restart");
    check("restart_single_write", (got.size() == 1) ? got[0] : '1, 64'h0000_0000_DEAD_BEEF);

    // Asynchronous reset while the 4th byte of a word is being offered.
    got.delete();
    pulse_start();
    begin
      logic [7:0] mb[5];
      mb = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
      for (int i = 0; i < 5; i++) send_byte(mb[i]);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h04;
    #2 reset = 1'b0;
    #1;
    check("async_reset_flags", 64'({byte_ready, wr_en, busy, error, core_reset}), 64'd0);
    check("async_reset_bus", {wr_addr, wr_data}, {BASE, 32'd0});
    repeat (2) @(negedge clk);
    check("async_reset_no_write", 64'(got.size()), 64'd0);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Full-depth image.
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h01);
    for (int i = 0; i < 4 * DEPTH; i++) stim.push_back(8'($urandom));
    run_load(1'b0, "full_depth");

    for (int r = 0; r < 20; r++) begin
      int n;
      stim.delete();
      if ($urandom_range(0, 5) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : 257 + $urandom_range(0, 300);
      else n = $urandom_range(1, 8);
      stim.push_back(8'(n));
      stim.push_back(8'(n >> 8));
      if (n >= 1 && n <= DEPTH)
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
      run_load($urandom_range(0, 1) == 1, $sformatf("rand%0d", r));
    end

`ifdef PMEM_LOADER_CHECKSUM_EN
    got.delete();
    pulse_start();
    begin
      logic [7:0] cb[7];
      cb = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      for (int i = 0; i < 7; i++) send_byte(cb[i]);
    end
    repeat (2) @(negedge clk);
    check("bad_checksum", 64'({error, core_reset}), 64'b10);
`endif

    check("wr_en_with_core_reset", 64'(overlap), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
